// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the fetch PC, issues imem requests and buffers responses for IF/ID
module fetch_unit #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RESET_PC  = '0,
    parameter int            BUF_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          valid_f_o,
    output logic [DW-1:0] instr_f_o,
    output logic [DW-1:0] pc_f_o,
    output logic [DW-1:0] pc_plus_4_f_o
);

    localparam int            CW  = $clog2(BUF_DEPTH + 1);
    localparam int            PW  = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam logic [DW-1:0] NOP = DW'(32'h0000_0013);

    logic [DW-1:0] fetch_pc;
    logic [DW-1:0] head_pc;
    logic [DW-1:0] redirect_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] resp_left;
    logic [CW:0]   load;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [DW-1:0] buf_mem [BUF_DEPTH];
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect_pc = redirect_pc_i & ~DW'(3);

    // Handshake decode; the slot freed by this cycle's pop is reusable at once so gnt=1 sustains one instr per cycle
    always_comb begin
        valid_f_o  = (buf_count != '0) && !redirect_i;
        pop        = valid_f_o && !stall_i;
        load       = {1'b0, outstanding} + {1'b0, buf_count} - {{CW{1'b0}}, pop};
        imem_req_o = rst_ni && !redirect_i && (load < (CW + 1)'(BUF_DEPTH));
        accept     = imem_req_o && imem_gnt_i;
        resp       = imem_rvalid_i && (outstanding != '0);
        push       = resp && (discard_cnt == '0) && !redirect_i;
        resp_left  = outstanding - CW'(resp);
    end

    // IF/ID facing outputs; NOP whenever no real instruction is presented
    always_comb begin
        imem_addr_o   = fetch_pc;
        instr_f_o     = valid_f_o ? buf_mem[rd_ptr] : NOP;
        pc_f_o        = head_pc;
        pc_plus_4_f_o = head_pc + DW'(4);
    end

    // Fetch PC and in-flight bookkeeping; a redirect turns every still-pending response into a discard
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= redirect_pc;
            outstanding <= resp_left;
            discard_cnt <= resp_left;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + DW'(4);
            outstanding <= outstanding + CW'(accept) - CW'(resp);
            if (resp && discard_cnt != '0)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

    // Buffer pointers and head PC; a redirect empties the buffer and restarts the presented PC
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_pc   <= RESET_PC;
            buf_count <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else if (redirect_i) begin
            head_pc   <= redirect_pc;
            buf_count <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            if (pop) begin
                head_pc <= head_pc + DW'(4);
                rd_ptr  <= ptr_inc(rd_ptr);
            end
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            buf_count <= buf_count + CW'(push) - CW'(pop);
        end
    end

    // Instruction storage; contents are meaningless while the matching count is zero, so no reset
    always_ff @(posedge clk_i) begin
        if (push)
            buf_mem[wr_ptr] <= imem_rdata_i;
    end

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> outstanding != '0);

    a_within_cap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, outstanding} + {1'b0, buf_count}) <= (CW + 1)'(BUF_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, reset sequence and random traffic checked against a queue-based model
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_f_o;
    logic [31:0] instr_f_o;
    logic [31:0] pc_f_o;
    logic [31:0] pc_plus_4_f_o;

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_f_o(valid_f_o), .instr_f_o(instr_f_o), .pc_f_o(pc_f_o), .pc_plus_4_f_o(pc_plus_4_f_o)
    );

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } flight_t;

    typedef struct {
        bit          gnt, rv, stall, redir;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    flight_t     q_fl[$];
    logic [31:0] q_buf[$];
    logic [31:0] m_fetch = '0;
    logic [31:0] m_head = '0;
    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input bit gnt, rv, stall, redir, input logic [31:0] rpc,
                               input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                               input logic [31:0] e_pc);
        vec_t r;
        r.gnt = gnt; r.rv = rv; r.stall = stall; r.redir = redir; r.rpc = rpc;
        r.e_req = e_req; r.e_addr = e_addr; r.e_valid = e_valid; r.e_pc = e_pc;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req_o), 32'd0);
        check({tag, "_addr"}, imem_addr_o, 32'h0);
        check({tag, "_valid"}, 32'(valid_f_o), 32'd0);
        check({tag, "_instr"}, instr_f_o, NOP);
        check({tag, "_pc"}, pc_f_o, 32'h0);
        check({tag, "_pc4"}, pc_plus_4_f_o, 32'h4);
    endtask

    // One clock: memory answers the oldest request when rv allows, outputs are checked, then the model advances
    task automatic cycle(input bit gnt, rv, stall, redir, input logic [31:0] rpc);
        bit          rsp, pop, req, vld;
        logic [31:0] e_instr;
        flight_t     e;
        @(negedge clk_i);
        rsp = rv && q_fl.size() > 0;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? (q_fl[0].addr ^ KEY) : $urandom;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        vld     = q_buf.size() > 0 && !redir;
        pop     = vld && !stall;
        req     = !redir && (q_fl.size() + q_buf.size() - int'(pop)) < 2;
        e_instr = vld ? (q_buf[0] ^ KEY) : NOP;
        #1;
        check("req", 32'(imem_req_o), 32'(req));
        check("addr", imem_addr_o, m_fetch);
        check("valid", 32'(valid_f_o), 32'(vld));
        check("instr", instr_f_o, e_instr);
        check("pc", pc_f_o, m_head);
        check("pc4", pc_plus_4_f_o, m_head + 32'd4);
        if (redir) begin
            if (rsp) void'(q_fl.pop_front());
            foreach (q_fl[k]) q_fl[k].live = 1'b0;
            q_buf.delete();
            m_fetch = rpc & ~32'h3;
            m_head  = m_fetch;
        end else begin
            if (pop) begin
                void'(q_buf.pop_front());
                m_head += 32'd4;
            end
            if (rsp) begin
                e = q_fl.pop_front();
                if (e.live) q_buf.push_back(e.addr);
            end
            if (req && gnt) begin
                q_fl.push_back('{m_fetch, 1'b1});
                m_fetch += 32'd4;
            end
        end
    endtask

    task automatic run_row(input int i);
        cycle(tbl[i].gnt, tbl[i].rv, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
        check($sformatf("row%0d_req", i), 32'(imem_req_o), 32'(tbl[i].e_req));
        check($sformatf("row%0d_addr", i), imem_addr_o, tbl[i].e_addr);
        check($sformatf("row%0d_valid", i), 32'(valid_f_o), 32'(tbl[i].e_valid));
        check($sformatf("row%0d_pc", i), pc_f_o, tbl[i].e_pc);
        check($sformatf("row%0d_pc4", i), pc_plus_4_f_o, tbl[i].e_pc + 32'd4);
        check($sformatf("row%0d_instr", i), instr_f_o, tbl[i].e_valid ? (tbl[i].e_pc ^ KEY) : NOP);
    endtask

    initial begin
        // streaming from reset, 3-cycle stall, gnt low twice, redirect to 0x103 with 2 in flight,
        // redirect together with stall, redirect near the top of the address space
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h0,       0,32'h0));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h4,       0,32'h0));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h8,       1,32'h0));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'hC,       1,32'h4));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h10,      1,32'h8));
        tbl.push_back(v(1,1,1,0,32'h0,        0,32'h14,      1,32'hC));
        tbl.push_back(v(1,1,1,0,32'h0,        0,32'h14,      1,32'hC));
        tbl.push_back(v(1,1,1,0,32'h0,        0,32'h14,      1,32'hC));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h14,      1,32'hC));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h18,      1,32'h10));
        tbl.push_back(v(0,1,0,0,32'h0,        1,32'h1C,      1,32'h14));
        tbl.push_back(v(0,1,0,0,32'h0,        1,32'h1C,      1,32'h18));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h1C,      0,32'h1C));
        tbl.push_back(v(1,0,0,0,32'h0,        1,32'h20,      0,32'h1C));
        tbl.push_back(v(1,0,0,1,32'h103,      0,32'h24,      0,32'h1C));
        tbl.push_back(v(1,1,0,0,32'h0,        0,32'h100,     0,32'h100));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h100,     0,32'h100));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h104,     0,32'h100));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h108,     1,32'h100));
        tbl.push_back(v(1,1,1,1,32'h200,      0,32'h10C,     0,32'h104));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h200,     0,32'h200));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h204,     0,32'h200));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h208,     1,32'h200));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h20C,     1,32'h204));
        tbl.push_back(v(1,1,0,1,32'hFFFFFFFE, 0,32'h210,     0,32'h208));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'hFFFFFFFC,0,32'hFFFFFFFC));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h0,       0,32'hFFFFFFFC));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h4,       1,32'hFFFFFFFC));
        tbl.push_back(v(1,1,0,0,32'h0,        1,32'h8,       1,32'h0));

        imem_gnt_i = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk_i);
        @(posedge clk_i) #2 rst_ni = 1'b1;
        foreach (tbl[i]) run_row(i);

        // asynchronous reset mid-stream with a stale response on the bus
        @(negedge clk_i);
        rst_ni = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check_reset_outputs("async_rst");
        q_fl.delete();
        q_buf.delete();
        m_fetch = '0;
        m_head  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("held_rst");
        @(posedge clk_i) #2 begin
            rst_ni = 1'b1;
            imem_rvalid_i = 1'b0;
        end
        for (int i = 0; i < 5; i++) run_row(i);

        // random traffic against the model
        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
